// File: rtl/result_uart_tx.sv
// result_uart_tx: sends the 16-bit result as four uppercase ASCII hex digits
// followed by CR LF over an 8N1 serial line (LSB first, idle high).
// Optional build macro RESULT_TX_AUTOSEND_EN: a change of data_in relative to
// the last transmitted value also starts a frame, in addition to send.
module result_uart_tx #(
  parameter int unsigned CLKS_PER_BIT = 868
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        clk_en,
  input  logic [15:0] data_in,
  input  logic        send,
  output logic        tx,
  output logic        busy,
  output logic        done
);

  localparam int unsigned CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CNT_W-1:0] BAUD_LAST = CNT_W'(CLKS_PER_BIT - 1);
  localparam logic [2:0] LAST_CHAR = 3'd5;
  localparam logic [2:0] LAST_BIT  = 3'd7;

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

  state_t           state;
  logic [CNT_W-1:0] baud_cnt;
  logic [2:0]       bit_idx;
  logic [2:0]       char_idx;
  logic [7:0]       cur_char;
  logic [15:0]      snap;
  logic             request_c;
  logic             baud_end_c;

`ifdef RESULT_TX_AUTOSEND_EN
  logic [15:0] last_sent;
  assign request_c = send || (data_in != last_sent);
`else
  assign request_c = send;
`endif

  assign baud_end_c = (baud_cnt == BAUD_LAST);

  // Nibble to uppercase ASCII hex digit
  function automatic logic [7:0] hex_ascii(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + 8'(n)) : (8'h37 + 8'(n));
  endfunction

  // Character at position idx of the frame built from value v
  function automatic logic [7:0] char_at(input logic [2:0] idx, input logic [15:0] v);
    logic [7:0] c;
    case (idx)
      3'd0:    c = hex_ascii(v[15:12]);
      3'd1:    c = hex_ascii(v[11:8]);
      3'd2:    c = hex_ascii(v[7:4]);
      3'd3:    c = hex_ascii(v[3:0]);
      3'd4:    c = 8'h0D;
      default: c = 8'h0A;
    endcase
    return c;
  endfunction

  // Frame sequencer: state, baud/bit/char counters and registered outputs
  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      tx       <= 1'b1;
      busy     <= 1'b0;
      done     <= 1'b0;
      baud_cnt <= '0;
      bit_idx  <= '0;
      char_idx <= '0;
      cur_char <= '0;
      snap     <= '0;
`ifdef RESULT_TX_AUTOSEND_EN
      last_sent <= '0;
`endif
    end else if (clk_en) begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (request_c) begin
            snap     <= data_in;
            char_idx <= '0;
            bit_idx  <= '0;
            cur_char <= char_at(3'd0, data_in);
            baud_cnt <= '0;
            tx       <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
`ifdef RESULT_TX_AUTOSEND_EN
            last_sent <= data_in;
`endif
          end
        end
        START: begin
          if (baud_end_c) begin
            baud_cnt <= '0;
            bit_idx  <= '0;
            tx       <= cur_char[0];
            state    <= DATA;
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        DATA: begin
          if (baud_end_c) begin
            baud_cnt <= '0;
            if (bit_idx == LAST_BIT) begin
              tx    <= 1'b1;
              state <= STOP;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              tx      <= cur_char[bit_idx + 3'd1];
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        STOP: begin
          if (baud_end_c) begin
            baud_cnt <= '0;
            if (char_idx != LAST_CHAR) begin
              char_idx <= char_idx + 3'd1;
              cur_char <= char_at(char_idx + 3'd1, snap);
              tx       <= 1'b0;
              state    <= START;
            end else begin
              tx    <= 1'b1;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= IDLE;
            end
          end else begin
            baud_cnt <= baud_cnt + CNT_W'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_result_uart_tx.sv
// Bench for result_uart_tx with CLKS_PER_BIT=4; expected serial streams are
// derived from the value's hex text plus CR LF, framed as start/8 data/stop.
module tb_result_uart_tx;

  localparam int unsigned CPB = 4;
  localparam int unsigned FRAME_CYC = 60 * CPB;

  logic        clk = 1'b0;
  logic        reset, clk_en, send;
  logic [15:0] data_in;
  logic        tx, busy, done;

  int unsigned passed = 0;
  int unsigned total  = 0;
  int unsigned failed = 0;
  logic        samples[$];
  string       hex_digits = "0123456789ABCDEF";

  result_uart_tx #(.CLKS_PER_BIT(CPB)) dut (
    .clk(clk), .reset(reset), .clk_en(clk_en), .data_in(data_in),
    .send(send), .tx(tx), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      failed++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Reference: character idx of the text "<4 hex digits>\r\n" for value v
  function automatic logic [7:0] exp_char(input logic [15:0] v, input int idx);
    case (idx)
      0:       return hex_digits[int'(v[15:12])];
      1:       return hex_digits[int'(v[11:8])];
      2:       return hex_digits[int'(v[7:4])];
      3:       return hex_digits[int'(v[3:0])];
      4:       return 8'h0D;
      default: return 8'h0A;
    endcase
  endfunction

  // Reference: k-th serial bit of the whole 60-bit frame
  function automatic logic exp_bit(input logic [15:0] v, input int k);
    logic [7:0] ch;
    int b;
    b  = k % 10;
    ch = exp_char(v, k / 10);
    if (b == 0) return 1'b0;
    if (b == 9) return 1'b1;
    return ch[b-1];
  endfunction

  // Launch one frame and check every enabled cycle of it against the reference
  task automatic run_frame(input string name, input logic [15:0] val, input bit use_send,
                           input bit toggle_en, input bit disturb);
    int cyc = 0, en_cnt = 0, done_seen = 0, frozen_bad = 0, bad_bits = 0, idle_act = 0;
    logic prev_tx, en_now;
    logic [9:0] word, exp_word;
    data_in = val; send = use_send; clk_en = 1'b1;
    tick();
    send = 1'b0;
    check({name, "_accept"}, {30'b0, busy, tx}, 32'b10);
    samples.delete();
    samples.push_back(tx);
    while (busy === 1'b1 && cyc < 2000) begin
      en_now = toggle_en ? logic'(cyc % 2 == 1) : 1'b1;
      clk_en = en_now;
      prev_tx = tx;
      if (disturb) begin
        if (cyc == 50) send = 1'b1;
        else if (cyc == 51) send = 1'b0;
        if (cyc == 60) data_in = 16'hFFFF;
      end
      tick();
      cyc++;
      if (en_now) begin
        en_cnt++;
        if (busy === 1'b1) samples.push_back(tx);
      end else if (tx !== prev_tx) frozen_bad++;
      if (busy === 1'b1 && done !== 1'b0) done_seen++;
    end
    data_in = val;
    check({name, "_cycles"}, 32'(cyc), toggle_en ? 32'(2 * FRAME_CYC) : 32'(FRAME_CYC));
    check({name, "_en_cycles"}, 32'(en_cnt), 32'(FRAME_CYC));
    check({name, "_nsamples"}, 32'(samples.size()), 32'(FRAME_CYC));
    check({name, "_end_done_tx_busy"}, {29'b0, done, tx, busy}, 32'b110);
    check({name, "_early_done"}, 32'(done_seen), 32'd0);
    if (toggle_en) begin
      check({name, "_frozen"}, 32'(frozen_bad), 32'd0);
      clk_en = 1'b0;
      tick();
      check({name, "_done_hold"}, {31'b0, done}, 32'd1);
      clk_en = 1'b1;
    end
    tick();
    check({name, "_done_clear"}, {31'b0, done}, 32'd0);
    for (int c = 0; c < 6; c++) begin
      for (int b = 0; b < 10; b++) word[b] = samples[c * 40 + b * 4 + 2];
      exp_word = {1'b1, exp_char(val, c), 1'b0};
      check($sformatf("%s_char%0d", name, c), {22'b0, word}, {22'b0, exp_word});
    end
    for (int k = 0; k < int'(FRAME_CYC); k++)
      if (samples[k] !== exp_bit(val, k / int'(CPB))) bad_bits++;
    check({name, "_bit_samples"}, 32'(bad_bits), 32'd0);
    if (disturb) begin
      for (int i = 0; i < 40; i++) begin
        tick();
        if (busy !== 1'b0 || tx !== 1'b1) idle_act++;
      end
      check({name, "_no_second_frame"}, 32'(idle_act), 32'd0);
    end
  endtask

  initial begin
    int act;
    logic [15:0] v;
    reset = 1'b1; clk_en = 1'b1; send = 1'b0; data_in = '0;
    for (int i = 0; i < 3; i++) begin
      data_in = 16'($urandom); send = 1'($urandom); clk_en = 1'($urandom);
      tick();
      check($sformatf("reset_hold%0d", i), {29'b0, tx, busy, done}, 32'b100);
    end
    reset = 1'b0; data_in = '0; send = 1'b0; clk_en = 1'b1;
    act = 0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) act++;
    end
    check("post_reset_idle", 32'(act), 32'd0);

    run_frame("basic", 16'h1A2F, 1'b1, 1'b0, 1'b0);
    run_frame("ignored", 16'h1A2F, 1'b1, 1'b0, 1'b1);
    run_frame("rand_a", 16'($urandom), 1'b1, 1'b0, 1'b0);
    run_frame("clk_en", 16'($urandom), 1'b1, 1'b1, 1'b0);

    // Abandon a frame with reset at cycle 100
    data_in = 16'($urandom); send = 1'b1;
    tick();
    send = 1'b0;
    repeat (99) tick();
    reset = 1'b1; data_in = '0;
    tick();
    check("mid_reset_outputs", {29'b0, tx, busy, done}, 32'b100);
    reset = 1'b0;
    act = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (tx !== 1'b1 || busy !== 1'b0 || done !== 1'b0) act++;
    end
    check("mid_reset_quiet", 32'(act), 32'd0);
    v = 16'($urandom);
    run_frame("after_reset", v, 1'b1, 1'b0, 1'b0);

    // Value change without send
    reset = 1'b1; data_in = '0;
    tick();
    reset = 1'b0;
    repeat (2) tick();
`ifdef RESULT_TX_AUTOSEND_EN
    run_frame("auto", 16'h00FF, 1'b0, 1'b0, 1'b0);
    act = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy !== 1'b0 || tx !== 1'b1) act++;
    end
    check("auto_steady", 32'(act), 32'd0);
    run_frame("auto_resend", 16'h00FF, 1'b1, 1'b0, 1'b0);
`else
    data_in = 16'h00FF;
    act = 0;
    for (int i = 0; i < 300; i++) begin
      tick();
      if (busy !== 1'b0 || tx !== 1'b1) act++;
    end
    check("no_autosend", 32'(act), 32'd0);
`endif

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
